lfsr_crc_stream: RTL and testbench

//  Sequential streaming CRC generator/checker built on a parallel Galois LFSR step.
//  - Consumes DATA_WIDTH-bit words over a valid/ready stream and carries the running

---
 rtl/lfsr_crc_stream.sv | 163 ++++++++++++++++
 tb/tb_lfsr_crc_stream.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_crc_stream.sv
// lfsr_crc_stream
// Streaming CRC generator/checker. Each accepted word advances a Galois LFSR
// by DATA_WIDTH bit steps in one cycle. The last word of a frame produces a
// held result: final CRC, residue-match flag and saturating word count.
module lfsr_crc_stream #(
    parameter int                      LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0]   LFSR_POLY  = 32'h04c11db7,
    parameter logic [LFSR_WIDTH-1:0]   INIT       = 32'hffffffff,
    parameter logic [LFSR_WIDTH-1:0]   XOR_OUT    = 32'hffffffff,
    parameter logic [LFSR_WIDTH-1:0]   RESIDUE    = 32'hdebb20e3,
    parameter bit                      REVERSE    = 1'b1,
    parameter int                      DATA_WIDTH = 8,
    parameter int                      LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_load,
    input  logic [LFSR_WIDTH-1:0] seed_val,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [LFSR_WIDTH-1:0] m_crc,
    output logic                  m_match,
    output logic [LEN_WIDTH-1:0]  m_len,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int W  = LFSR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    localparam logic [W-1:0] POLY_R = bit_rev(LFSR_POLY);

    // Reference bit-serial step; only evaluated at elaboration to derive the
    // XOR masks, so it never becomes a DW-deep chain in hardware.
    function automatic logic [W-1:0] serial_step(input logic [W-1:0] st,
                                                 input logic [DW-1:0] d);
        logic [W-1:0] s;
        logic         fb;
        s = st;
        for (int k = 0; k < DW; k++) begin
            if (REVERSE) begin
                fb = s[0] ^ d[k];
                s  = (s >> 1) ^ (fb ? POLY_R : '0);
            end else begin
                fb = s[W-1] ^ d[DW-1-k];
                s  = (s << 1) ^ (fb ? LFSR_POLY : '0);
            end
        end
        return s;
    endfunction

    // The word step is linear over GF(2): next = XOR of the columns selected
    // by each set state bit and each set data bit.
    logic [W-1:0] st_col [W];
    logic [W-1:0] d_col  [DW];

    for (genvar i = 0; i < W; i++) begin : g_st_col
        localparam logic [W-1:0] COL = serial_step(W'(1) << i, '0);
        assign st_col[i] = COL;
    end

    for (genvar k = 0; k < DW; k++) begin : g_d_col
        localparam logic [W-1:0] COL = serial_step('0, DW'(1) << k);
        assign d_col[k] = COL;
    end

    logic [W-1:0]         state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 busy_q, busy_d;
    logic                 m_valid_q, m_valid_d;
    logic [W-1:0]         m_crc_q, m_crc_d;
    logic                 m_match_q, m_match_d;
    logic [LEN_WIDTH-1:0] m_len_q, m_len_d;

    logic [W-1:0]         base;
    logic [W-1:0]         step_res;
    logic [LEN_WIDTH-1:0] len_inc;
    logic                 accept;

    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;
    assign base    = seed_load ? seed_val : state_q;
    assign len_inc = (len_q == LEN_MAX) ? len_q : len_q + LEN_WIDTH'(1);

    // Parallel LFSR word step from the constant column masks.
    always_comb begin
        step_res = '0;
        for (int i = 0; i < W; i++)
            if (base[i]) step_res = step_res ^ st_col[i];
        for (int k = 0; k < DW; k++)
            if (s_data[k]) step_res = step_res ^ d_col[k];
    end

    // Next-state: seed, word accumulation, frame close and result handshake.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        len_d     = len_q;
        busy_d    = busy_q;
        m_valid_d = m_valid_q;
        m_crc_d   = m_crc_q;
        m_match_d = m_match_q;
        m_len_d   = m_len_q;

        if (seed_load) state_d = seed_val;
        if (m_valid_q && m_ready) m_valid_d = 1'b0;

        if (accept) begin
            if (s_last) begin
                m_crc_d   = step_res ^ XOR_OUT;
                m_match_d = (step_res == RESIDUE);
                m_len_d   = len_inc;
                m_valid_d = 1'b1;
                state_d   = INIT;
                len_d     = '0;
                busy_d    = 1'b0;
            end else begin
                state_d   = step_res;
                len_d     = len_inc;
                busy_d    = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= INIT;
            len_q     <= '0;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_crc_q   <= '0;
            m_match_q <= 1'b0;
            m_len_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            m_valid_q <= m_valid_d;
            m_crc_q   <= m_crc_d;
            m_match_q <= m_match_d;
            m_len_q   <= m_len_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_crc   = m_crc_q;
    assign m_match = m_match_q;
    assign m_len   = m_len_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_lfsr_crc_stream.sv
// Bench for lfsr_crc_stream (CRC-32, reflected, byte stream). Expected results
// come from a byte-wise reflected CRC-32 model and known check values.
module tb_lfsr_crc_stream;

    typedef struct packed {
        logic [31:0] crc;
        logic        match;
        logic [15:0] len;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [31:0] seed_val = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;
    logic        s_ready, m_match, m_valid, busy;
    logic [31:0] m_crc;
    logic [15:0] m_len;
    logic        s2_ready, m2_match, m2_valid, busy2;
    logic [31:0] m2_crc;
    logic [1:0]  m2_len;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rand_en = 1'b0;
    res_t res_q[$];
    logic [1:0] len2_q[$];

    lfsr_crc_stream dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_val(seed_val),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_crc(m_crc), .m_match(m_match), .m_len(m_len), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy)
    );

    lfsr_crc_stream #(.LEN_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_val(seed_val),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s2_ready),
        .m_crc(m2_crc), .m_match(m2_match), .m_len(m2_len), .m_valid(m2_valid),
        .m_ready(m_ready), .busy(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Consumed results, observed mid-cycle when the handshake inputs are settled.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) res_q.push_back('{m_crc, m_match, m_len});
        if (!rst && m2_valid && m_ready) len2_q.push_back(m2_len);
    end

    // Random consumer back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_en) m_ready = 1'($urandom_range(0, 1));
    end

    // Reflected CRC-32, processed a byte at a time; returns the raw register.
    function automatic logic [31:0] model_raw(input logic [31:0] init, input logic [7:0] b[$]);
        logic [31:0] c;
        c = init;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic res_t model_res(input logic [31:0] init, input logic [7:0] b[$]);
        logic [31:0] raw;
        int          n;
        raw = model_raw(init, b);
        n   = b.size();
        return '{raw ^ 32'hffffffff, raw == 32'hdebb20e3, (n > 65535) ? 16'hffff : 16'(n)};
    endfunction

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; seed_load = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last, input logic seed,
                             input logic [31:0] sv);
        bit accepted;
        int waits;
        accepted = 1'b0; waits = 0;
        s_data = d; s_last = last; s_valid = 1'b1; seed_load = seed; seed_val = sv;
        while (!accepted) begin
            @(negedge clk);
            if (s_ready) accepted = 1'b1;
            cycle();
            if (!accepted) begin
                waits++;
                if (waits > 200) begin
                    n_cmp++; n_bad++;
                    $display("FAIL accept_timeout: s_ready stayed 0 for %0d cycles, required 1", waits);
                    break;
                end
            end
        end
        seed_load = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b[$], input logic seed, input logic [31:0] sv,
                              input bit gaps);
        foreach (b[i]) begin
            send_word(b[i], i == b.size() - 1, seed && (i == 0), sv);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0; cycle();
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (res_q.size() < n && t < 300) begin cycle(); t++; end
        repeat (3) cycle();
        n_cmp++;
        if (res_q.size() !== n) begin
            n_bad++;
            $display("FAIL result_count: got %0d results, required %0d", res_q.size(), n);
        end
    endtask

    task automatic cmp_res(input string name, input res_t exp);
        res_t got;
        if (res_q.size() == 0) return;
        got = res_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got crc=%h match=%b len=%0d, required crc=%h match=%b len=%0d",
                     name, got.crc, got.match, got.len, exp.crc, exp.match, exp.len);
        end
    endtask

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endfunction

    logic [7:0] check9[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    task automatic test_reset();
        rst = 1'b1; cycle(); cycle();
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_crc", m_crc, 32'd0);
        chk("reset_m_match", 32'(m_match), 32'd0);
        chk("reset_m_len", 32'(m_len), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_s_ready", 32'(s_ready), 32'd1);
        rst = 1'b0; cycle();
    endtask

    task automatic test_check_vector();
        res_q.delete();
        m_ready = 1'b1;
        send_word(check9[0], 1'b0, 1'b0, '0);
        chk("busy_after_first_word", 32'(busy), 32'd1);
        for (int i = 1; i < 9; i++) send_word(check9[i], i == 8, 1'b0, '0);
        s_valid = 1'b0; s_last = 1'b0;
        chk("busy_after_last_word", 32'(busy), 32'd0);
        wait_results(1);
        cmp_res("check_123456789", '{32'hcbf43926, 1'b0, 16'd9});
    endtask

    task automatic test_residue();
        logic [7:0] fr[$];
        res_q.delete();
        fr = check9;
        fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hf4); fr.push_back(8'hcb);
        send_frame(fr, 1'b0, '0, 1'b0);
        wait_results(1);
        cmp_res("residue_good", '{32'h2144df1c, 1'b1, 16'd13});
        fr[3] = fr[3] ^ 8'h10;
        send_frame(fr, 1'b0, '0, 1'b0);
        wait_results(1);
        if (res_q.size() > 0) begin
            chk("residue_bad_match", 32'(res_q[0].match), 32'd0);
            cmp_res("residue_bad", model_res(32'hffffffff, fr));
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] fr[$];
        res_q.delete();
        fr = '{8'h00};
        send_frame(fr, 1'b0, '0, 1'b0);
        chk("single_busy", 32'(busy), 32'd0);
        wait_results(1);
        cmp_res("single_00", '{32'hd202ef8d, 1'b0, 16'd1});
    endtask

    task automatic test_stall();
        res_t held;
        logic [7:0] fa[$], fb[$];
        res_q.delete();
        fa = '{8'hab}; fb = '{8'h5c};
        m_ready = 1'b0;
        send_word(8'hab, 1'b1, 1'b0, '0);
        held = '{m_crc, m_match, m_len};
        chk("stall_first_crc", held.crc, model_res(32'hffffffff, fa).crc);
        s_data = 8'h5c; s_last = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_s_ready", 32'(s_ready), 32'd0);
            chk("stall_m_valid", 32'(m_valid), 32'd1);
            chk("stall_m_stable", {m_crc}, held.crc);
            chk("stall_m_len_stable", {m_match, 15'd0, m_len}, {held.match, 15'd0, held.len});
            cycle();
        end
        m_ready = 1'b1;
        send_word(8'h5c, 1'b1, 1'b0, '0);
        s_valid = 1'b0; s_last = 1'b0;
        chk("b2b_m_valid_held", 32'(m_valid), 32'd1);
        wait_results(2);
        cmp_res("b2b_first", model_res(32'hffffffff, fa));
        cmp_res("b2b_second", model_res(32'hffffffff, fb));
    endtask

    task automatic test_reset_midframe();
        res_q.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_word(8'($urandom), 1'b0, 1'b0, '0);
        do_reset();
        chk("midreset_busy", 32'(busy), 32'd0);
        send_frame(check9, 1'b0, '0, 1'b0);
        wait_results(1);
        cmp_res("midreset_check", '{32'hcbf43926, 1'b0, 16'd9});
        m_ready = 1'b0;
        send_word(8'h77, 1'b1, 1'b0, '0);
        s_valid = 1'b0; s_last = 1'b0;
        do_reset();
        chk("reset_drops_pending", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        res_q.delete();
        wait_results(0);
    endtask

    task automatic test_seed();
        logic [7:0]  fr[$];
        logic [31:0] sd;
        res_q.delete();
        seed_val = $urandom; seed_load = 1'b1; cycle(); seed_load = 1'b0;
        chk("seed_idle_busy", 32'(busy), 32'd0);
        send_frame(check9, 1'b1, 32'hffffffff, 1'b0);
        wait_results(1);
        cmp_res("seed_init_check", '{32'hcbf43926, 1'b0, 16'd9});
        sd = $urandom;
        fr.delete();
        for (int i = 0; i < 7; i++) fr.push_back(8'($urandom));
        send_frame(fr, 1'b1, sd, 1'b0);
        wait_results(1);
        cmp_res("seed_random", model_res(sd, fr));
    endtask

    task automatic test_saturate();
        logic [7:0] fr[$];
        res_q.delete(); len2_q.delete();
        for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
        send_frame(fr, 1'b0, '0, 1'b0);
        wait_results(1);
        cmp_res("sat_wide", model_res(32'hffffffff, fr));
        n_cmp++;
        if (len2_q.size() != 1 || len2_q[0] !== 2'd3) begin
            n_bad++;
            $display("FAIL sat_len2: got %0d results first len %0d, required 1 result len 3",
                     len2_q.size(), (len2_q.size() > 0) ? len2_q[0] : 2'd0);
        end
    endtask

    task automatic test_random();
        res_t       exp_q[$];
        logic [1:0] exp2_q[$];
        logic [7:0] fr[$];
        logic [31:0] sd;
        bit          sdl;
        int          n;
        res_q.delete(); len2_q.delete();
        rand_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            fr.delete();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
            sdl = ($urandom_range(0, 4) == 0);
            sd  = $urandom;
            send_frame(fr, sdl, sd, 1'b1);
            exp_q.push_back(model_res(sdl ? sd : 32'hffffffff, fr));
            exp2_q.push_back((n > 3) ? 2'd3 : 2'(n));
        end
        rand_en = 1'b0;
        #2; m_ready = 1'b1;
        wait_results(30);
        foreach (exp_q[i]) cmp_res("random_frame", exp_q[i]);
        n_cmp++;
        if (len2_q !== exp2_q) begin
            n_bad++;
            $display("FAIL random_len2: got %0d narrow lengths, required %0d matching lengths",
                     len2_q.size(), exp2_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_check_vector();
        test_residue();
        test_single_byte();
        test_stall();
        test_reset_midframe();
        test_seed();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
